// File: rtl/cp_phase_gen_if.sv
// Configuration and output bundle of the charge-pump phase generator.
// The bench drives it through master; the generator connects through slave.
interface cp_phase_gen_if #(
  parameter int NUM_PHASES = 2,
  parameter int DIV_W      = 8,
  parameter int DT_W       = 4,
  parameter int CNT_W      = 16
);
  logic                  en;
  logic [DIV_W-1:0]      div;
  logic [DT_W-1:0]       dead;
  logic                  comp_in;
  logic [NUM_PHASES-1:0] phase_out;
  logic                  running;
  logic [CNT_W-1:0]      cyc_cnt;

  modport master (
    output en, div, dead, comp_in,
    input  phase_out, running, cyc_cnt
  );

  modport slave (
    input  en, div, dead, comp_in,
    output phase_out, running, cyc_cnt
  );
endinterface

// File: rtl/cp_phase_gen.sv
// N-phase non-overlapping charge-pump clock with pulse-skip regulation.
// Optional soft-start on-time ramp is built when CP_SOFT_START_EN is defined.
module cp_phase_gen #(
  parameter int NUM_PHASES = 2,
  parameter int DIV_W      = 8,
  parameter int DT_W       = 4,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  cp_phase_gen_if.slave  bus
);

  localparam int IDX_W = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;
  localparam int TMR_W = (DIV_W > DT_W) ? DIV_W : DT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    ON   = 2'd2,
    DEAD = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nx_s;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      idx_nx_s;
  logic [TMR_W-1:0]      timer_r;
  logic [TMR_W-1:0]      timer_nx_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_nx_s;
  logic [NUM_PHASES-1:0] phase_r;
  logic                  running_r;
  logic                  comp_meta_r;
  logic                  comp_sync_r;
  logic [DIV_W-1:0]      on_lat_s;

  state_t                adv_state_s;
  logic [IDX_W-1:0]      adv_idx_s;
  logic [TMR_W-1:0]      adv_timer_s;
  logic [CNT_W-1:0]      adv_cnt_s;

  function automatic logic [NUM_PHASES-1:0] phase_sel(
    input logic [IDX_W-1:0] idx,
    input logic             on
  );
    logic [NUM_PHASES-1:0] v;
    for (int k = 0; k < NUM_PHASES; k++) begin
      v[k] = on && (idx == IDX_W'(k));
    end
    return v;
  endfunction

`ifdef CP_SOFT_START_EN
  logic [DIV_W-1:0] ramp_r;
  logic [DIV_W-1:0] ramp_nx_s;
  logic [DIV_W-1:0] adv_ramp_s;

  // On-time actually latched: the ramp caps div until it catches up
  always_comb begin
    if (ramp_r < bus.div) begin
      on_lat_s = ramp_r;
    end else begin
      on_lat_s = bus.div;
    end
  end
`else
  assign on_lat_s = bus.div;
`endif

  // Comparator is asynchronous to clk; two flops before the FSM looks at it
  always_ff @(posedge clk) begin
    if (rst) begin
      comp_meta_r <= 1'b0;
      comp_sync_r <= 1'b0;
    end else begin
      comp_meta_r <= bus.comp_in;
      comp_sync_r <= comp_meta_r;
    end
  end

  // Next-phase rule shared by the end of ON (no gap) and the end of DEAD
  always_comb begin
    adv_state_s = ON;
    adv_idx_s   = idx_r + IDX_W'(1'b1);
    adv_timer_s = TMR_W'(on_lat_s);
    adv_cnt_s   = cnt_r;
`ifdef CP_SOFT_START_EN
    adv_ramp_s  = ramp_r;
`endif
    if (idx_r == LAST_IDX) begin
      adv_state_s = SKIP;
      adv_idx_s   = {IDX_W{1'b0}};
      adv_timer_s = {TMR_W{1'b0}};
      if (cnt_r == {CNT_W{1'b1}}) begin
        adv_cnt_s = cnt_r;
      end else begin
        adv_cnt_s = cnt_r + CNT_W'(1'b1);
      end
`ifdef CP_SOFT_START_EN
      if (ramp_r < bus.div) begin
        adv_ramp_s = ramp_r + DIV_W'(1'b1);
      end else begin
        adv_ramp_s = ramp_r;
      end
`endif
    end else begin
      adv_state_s = ON;
    end
  end

  // FSM next-state: en low always returns to IDLE from any active state
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    timer_nx_s = timer_r;
    cnt_nx_s   = cnt_r;
`ifdef CP_SOFT_START_EN
    ramp_nx_s  = ramp_r;
`endif
    case (state_r)
      IDLE: begin
        idx_nx_s   = {IDX_W{1'b0}};
        timer_nx_s = {TMR_W{1'b0}};
        if (bus.en) begin
          state_nx_s = SKIP;
`ifdef CP_SOFT_START_EN
          ramp_nx_s  = {DIV_W{1'b0}};
`endif
        end else begin
          state_nx_s = IDLE;
        end
      end
      SKIP: begin
        if (!bus.en) begin
          state_nx_s = IDLE;
          idx_nx_s   = {IDX_W{1'b0}};
          timer_nx_s = {TMR_W{1'b0}};
        end else if (comp_sync_r) begin
          state_nx_s = SKIP;
        end else begin
          state_nx_s = ON;
          idx_nx_s   = {IDX_W{1'b0}};
          timer_nx_s = TMR_W'(on_lat_s);
        end
      end
      ON: begin
        if (!bus.en) begin
          state_nx_s = IDLE;
          idx_nx_s   = {IDX_W{1'b0}};
          timer_nx_s = {TMR_W{1'b0}};
        end else if (timer_r != {TMR_W{1'b0}}) begin
          timer_nx_s = timer_r - TMR_W'(1'b1);
        end else if (bus.dead != {DT_W{1'b0}}) begin
          state_nx_s = DEAD;
          timer_nx_s = TMR_W'(bus.dead) - TMR_W'(1'b1);
        end else begin
          state_nx_s = adv_state_s;
          idx_nx_s   = adv_idx_s;
          timer_nx_s = adv_timer_s;
          cnt_nx_s   = adv_cnt_s;
`ifdef CP_SOFT_START_EN
          ramp_nx_s  = adv_ramp_s;
`endif
        end
      end
      DEAD: begin
        if (!bus.en) begin
          state_nx_s = IDLE;
          idx_nx_s   = {IDX_W{1'b0}};
          timer_nx_s = {TMR_W{1'b0}};
        end else if (timer_r != {TMR_W{1'b0}}) begin
          timer_nx_s = timer_r - TMR_W'(1'b1);
        end else begin
          state_nx_s = adv_state_s;
          idx_nx_s   = adv_idx_s;
          timer_nx_s = adv_timer_s;
          cnt_nx_s   = adv_cnt_s;
`ifdef CP_SOFT_START_EN
          ramp_nx_s  = adv_ramp_s;
`endif
        end
      end
      default: begin
        state_nx_s = IDLE;
        idx_nx_s   = {IDX_W{1'b0}};
        timer_nx_s = {TMR_W{1'b0}};
      end
    endcase
  end

  // State and outputs; phase_out is decoded from next-state so pins come straight off flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      idx_r     <= {IDX_W{1'b0}};
      timer_r   <= {TMR_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      phase_r   <= {NUM_PHASES{1'b0}};
      running_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      idx_r     <= idx_nx_s;
      timer_r   <= timer_nx_s;
      cnt_r     <= cnt_nx_s;
      phase_r   <= phase_sel(idx_nx_s, state_nx_s == ON);
      running_r <= (state_nx_s != IDLE);
    end
  end

`ifdef CP_SOFT_START_EN
  // Soft-start ramp register
  always_ff @(posedge clk) begin
    if (rst) begin
      ramp_r <= {DIV_W{1'b0}};
    end else begin
      ramp_r <= ramp_nx_s;
    end
  end
`endif

  assign bus.phase_out = phase_r;
  assign bus.running   = running_r;
  assign bus.cyc_cnt   = cnt_r;

endmodule

// File: tb/tb_cp_phase_gen.sv
// Scoreboard bench for cp_phase_gen: a 2-phase instance and a 4-phase
// instance with a 4-bit rotation counter so saturation is reachable.
`timescale 1ns/1ps
module tb_cp_phase_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en_a;
  logic       en_b;
  logic       comp_v;
  logic [7:0] div_v;
  logic [3:0] dead_v;

  cp_phase_gen_if #(.NUM_PHASES(2)) if_a ();
  cp_phase_gen_if #(.NUM_PHASES(4), .CNT_W(4)) if_b ();

  assign if_a.en      = en_a;
  assign if_a.div     = div_v;
  assign if_a.dead    = dead_v;
  assign if_a.comp_in = comp_v;
  assign if_b.en      = en_b;
  assign if_b.div     = div_v;
  assign if_b.dead    = dead_v;
  assign if_b.comp_in = comp_v;

  cp_phase_gen #(.NUM_PHASES(2)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  cp_phase_gen #(.NUM_PHASES(4), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  typedef struct {
    int          sel;
    logic [7:0]  ph;
    logic        run;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt [2];
  int   cnt_max [2];
  int   rot_no;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  // Monitor: one expectation per edge, sampled 1ns after it
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.sel == 0) begin
        check_val("phase_a", 32'(if_a.phase_out), 32'(e.ph));
        check_val("run_a",   32'(if_a.running),   32'(e.run));
        check_val("cnt_a",   32'(if_a.cyc_cnt),   32'(e.cnt));
      end else begin
        check_val("phase_b", 32'(if_b.phase_out), 32'(e.ph));
        check_val("run_b",   32'(if_b.running),   32'(e.run));
        check_val("cnt_b",   32'(if_b.cyc_cnt),   32'(e.cnt));
      end
    end
  end

  // Expected per-phase on-time for the current rotation since enable
  function automatic int on_time(input int d, input int r);
`ifdef CP_SOFT_START_EN
    return (((r - 1) < d) ? (r - 1) : d) + 1;
`else
    return d + 1 + (r - r);
`endif
  endfunction

  task automatic set_en(input int sel, input logic v);
    if (sel == 0) en_a = v;
    else          en_b = v;
  endtask

  task automatic cyc(input int sel, input logic [7:0] ph, input logic run);
    exp_t e;
    e.sel = sel;
    e.ph  = ph;
    e.run = run;
    e.cnt = 16'(exp_cnt[sel]);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic enable(input int sel);
    set_en(sel, 1'b1);
    rot_no = 1;
    cyc(sel, 8'h00, 1'b1);
  endtask

  task automatic rot_cycle(input int sel, input int i, input int comp_at, input int abort_at,
                           input logic [7:0] ph, output bit aborted);
    aborted = 1'b0;
    if (i == comp_at) comp_v = 1'b1;
    if (i == abort_at) begin
      set_en(sel, 1'b0);
      cyc(sel, 8'h00, 1'b0);
      aborted = 1'b1;
    end else begin
      cyc(sel, ph, 1'b1);
    end
  endtask

  // One full rotation from the first ON cycle through the following SKIP cycle
  task automatic rotation(input int sel, input int nph, input int comp_at, input int abort_at,
                          output bit aborted);
    int         t_on;
    int         i;
    logic [7:0] one;
    t_on    = on_time(int'(div_v), rot_no);
    i       = 0;
    one     = 8'h01;
    aborted = 1'b0;
    for (int p = 0; p < nph; p++) begin
      for (int c = 0; c < t_on; c++) begin
        rot_cycle(sel, i, comp_at, abort_at, one << p, aborted);
        i++;
        if (aborted) return;
      end
      for (int c = 0; c < int'(dead_v); c++) begin
        rot_cycle(sel, i, comp_at, abort_at, 8'h00, aborted);
        i++;
        if (aborted) return;
      end
    end
    if (exp_cnt[sel] < cnt_max[sel]) exp_cnt[sel]++;
    rot_no++;
    cyc(sel, 8'h00, 1'b1);
  endtask

  initial begin : stim
    bit ab;
    int ab_at;
    rst        = 1'b1;
    en_a       = 1'b0;
    en_b       = 1'b0;
    comp_v     = 1'b0;
    div_v      = 8'd3;
    dead_v     = 4'd1;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    cnt_max[0] = 65535;
    cnt_max[1] = 15;
    repeat (2) @(negedge clk);

    // reset state of both instances
    cyc(0, 8'h00, 1'b0);
    cyc(1, 8'h00, 1'b0);
    rst = 1'b0;
    cyc(0, 8'h00, 1'b0);

    // basic rotation, div=3 dead=1
    enable(0);
    rotation(0, 2, -1, -1, ab);
    rotation(0, 2, -1, -1, ab);

    // comparator high mid-rotation: rotation finishes, then skip
    rotation(0, 2, 1, -1, ab);
    repeat (5) cyc(0, 8'h00, 1'b1);
    comp_v = 1'b0;
    cyc(0, 8'h00, 1'b1);
    cyc(0, 8'h00, 1'b1);
    rotation(0, 2, -1, -1, ab);

    // enable drop in the 2nd cycle of phase 1's ON, then restart
    ab_at = on_time(int'(div_v), rot_no) + int'(dead_v) + 2;
    rotation(0, 2, -1, ab_at, ab);
    check_val("abort_seen", 32'(ab), 32'd1);
    cyc(0, 8'h00, 1'b0);
    enable(0);
    rotation(0, 2, -1, -1, ab);
    en_a = 1'b0;
    cyc(0, 8'h00, 1'b0);

    // zero dead time on 4 phases, run into counter saturation
    div_v  = 8'd0;
    dead_v = 4'd0;
    enable(1);
    repeat (18) rotation(1, 4, -1, -1, ab);

    // reset in the middle of a rotation
    cyc(1, 8'h01, 1'b1);
    rst        = 1'b1;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    cyc(1, 8'h00, 1'b0);
    rst  = 1'b0;
    en_b = 1'b0;
    cyc(1, 8'h00, 1'b0);

    // soft-start profile (or constant on-time without the ramp)
    div_v  = 8'd4;
    dead_v = 4'd0;
    enable(0);
    repeat (6) rotation(0, 2, -1, -1, ab);
    en_a = 1'b0;
    cyc(0, 8'h00, 1'b0);

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
